// File: rtl/shift_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : shift_seq_pkg                                          |
// | Purpose  : Shared widths, direction encoding and FSM state type   |
// |            for the sequential shifter shift_seq_32.               |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package shift_seq_pkg;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_step_32.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : shift_step_32                                          |
// | Purpose  : One-bit combinational shift step: hold, left (zero     |
// |            fill) or right (fill bit supplied by the caller).      |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module shift_step_32
  import shift_seq_pkg::*;
(
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_dout
);

  // Hold when disabled, otherwise move one bit in the requested direction
  always_comb begin
    o_dout = i_din;
    if (i_en) begin
      if (i_dir == DIR_LEFT) begin
        o_dout = {i_din[WIDTH-2:0], 1'b0};
      end else begin
        o_dout = {i_fill, i_din[WIDTH-1:1]};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_seq_32.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : shift_seq_32                                           |
// | Purpose  : Sequential barrel-free shifter, one bit per clock,     |
// |            valid/ready request and result handshakes, abort.      |
// | Options  : SHIFT_ARITH_EN adds port ARITH (sign-fill right shift);|
// |            without it all right shifts are logical.               |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module shift_seq_32
  import shift_seq_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START_VALID,
  output logic             START_READY,
  input  logic [WIDTH-1:0] DIN,
  input  logic [AMT_W-1:0] AMT,
  input  logic             DIR,
`ifdef SHIFT_ARITH_EN
  input  logic             ARITH,
`endif
  input  logic             ABORT,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] DOUT,
  output logic             L_SHIFT,
  output logic             R_SHIFT,
  output logic             NO_SHIFT,
  output logic             BUSY
);

  localparam logic [AMT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [AMT_W-1:0] c_CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_dout;
  logic [AMT_W-1:0] r_count;
  logic             r_dir;
  logic             w_accept;
  logic             w_fill;
  logic [WIDTH-1:0] w_step;

  // Acceptance only happens in IDLE, so START_READY doubles as the gate
  assign w_accept = START_VALID & (r_state == ST_IDLE);

`ifdef SHIFT_ARITH_EN
  logic r_arith;

  // Latched sign-fill request, captured only at acceptance
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_arith <= 1'b0;
    end else if (w_accept) begin
      r_arith <= ARITH;
    end
  end

  assign w_fill = r_arith & r_dout[WIDTH-1];
`else
  assign w_fill = 1'b0;
`endif

  shift_step_32 u_step (
    .i_din  (r_dout),
    .i_en   (r_state == ST_SHIFT),
    .i_dir  (r_dir),
    .i_fill (w_fill),
    .o_dout (w_step)
  );

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode; ABORT outranks the result handshake
  always_comb begin
    w_next_state = r_state;
    START_READY  = 1'b0;
    RES_VALID    = 1'b0;
    BUSY         = 1'b1;
    L_SHIFT      = 1'b0;
    R_SHIFT      = 1'b0;
    NO_SHIFT     = 1'b1;
    case (r_state)
      ST_IDLE: begin
        START_READY = 1'b1;
        BUSY        = 1'b0;
        if (START_VALID) begin
          w_next_state = (AMT == c_CNT_ZERO) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        NO_SHIFT = 1'b0;
        L_SHIFT  = (r_dir == DIR_LEFT);
        R_SHIFT  = (r_dir == DIR_RIGHT);
        if (ABORT) begin
          w_next_state = ST_IDLE;
        end else if (r_count == c_CNT_ONE) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        RES_VALID = 1'b1;
        if (ABORT || RES_READY) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Working register, step counter and latched direction
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dout  <= '0;
      r_count <= '0;
      r_dir   <= DIR_LEFT;
    end else if (w_accept) begin
      r_dout  <= DIN;
      r_count <= AMT;
      r_dir   <= DIR;
    end else if ((r_state == ST_SHIFT) && !ABORT) begin
      r_dout  <= w_step;
      r_count <= r_count - c_CNT_ONE;
    end
  end

  assign DOUT = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_32.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_shift_seq_32                                        |
// | Purpose  : Self-checking bench for shift_seq_32 (table of         |
// |            operations plus abort / reset sequences).              |
// | Options  : honours SHIFT_ARITH_EN for ARITH port and expectations.|
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_shift_seq_32;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START_VALID;
  logic        START_READY;
  logic [31:0] DIN;
  logic [4:0]  AMT;
  logic        DIR;
`ifdef SHIFT_ARITH_EN
  logic        ARITH;
`endif
  logic        ABORT;
  logic        RES_VALID;
  logic        RES_READY;
  logic [31:0] DOUT;
  logic        L_SHIFT;
  logic        R_SHIFT;
  logic        NO_SHIFT;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] din;
    logic [4:0]  amt;
    logic        dir;
    logic        arith;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[9];

  always #5 CLK = ~CLK;

  shift_seq_32 dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .START_VALID (START_VALID),
    .START_READY (START_READY),
    .DIN         (DIN),
    .AMT         (AMT),
    .DIR         (DIR),
`ifdef SHIFT_ARITH_EN
    .ARITH       (ARITH),
`endif
    .ABORT       (ABORT),
    .RES_VALID   (RES_VALID),
    .RES_READY   (RES_READY),
    .DOUT        (DOUT),
    .L_SHIFT     (L_SHIFT),
    .R_SHIFT     (R_SHIFT),
    .NO_SHIFT    (NO_SHIFT),
    .BUSY        (BUSY)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"},        DOUT,        32'h0);
    chk({tag, "_start_ready"}, START_READY, 32'h1);
    chk({tag, "_res_valid"},   RES_VALID,   32'h0);
    chk({tag, "_busy"},        BUSY,        32'h0);
    chk({tag, "_no_shift"},    NO_SHIFT,    32'h1);
    chk({tag, "_l_shift"},     L_SHIFT,     32'h0);
    chk({tag, "_r_shift"},     R_SHIFT,     32'h0);
  endtask

  // One complete operation: request, count strobes, check latency/result,
  // optionally stall the consumer, then hand-shake the result away.
  task automatic run_op(input logic [31:0] din, input logic [4:0] amt, input logic dir,
                        input logic arith, input logic [31:0] exp, input int hold);
    int cyc;
    int lc;
    int rc;
    logic [31:0] held;
    logic [31:0] want;
    @(negedge CLK);
    chk("start_ready_idle", START_READY, 32'h1);
    START_VALID = 1'b1;
    DIN = din;
    AMT = amt;
    DIR = dir;
`ifdef SHIFT_ARITH_EN
    ARITH = arith;
`endif
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    START_VALID = 1'b0;
    DIN = $urandom;
    AMT = 5'($urandom);
    DIR = ~dir;
`ifdef SHIFT_ARITH_EN
    ARITH = ~arith;
`endif
    cyc = 0;
    lc = 0;
    rc = 0;
    while (!RES_VALID && cyc < 64) begin
      if (L_SHIFT) lc++;
      if (R_SHIFT) rc++;
      @(posedge CLK);
      #1;
      cyc++;
    end
    if (!RES_VALID) begin
      checks++;
      errors++;
      $display("FAIL res_valid_timeout: got no RES_VALID after %0d cycles, expected one after %0d", cyc, amt);
    end
    chk("latency",       cyc, 32'(amt));
    chk("l_shift_count", lc,  (dir == 1'b0) ? 32'(amt) : 32'h0);
    chk("r_shift_count", rc,  (dir == 1'b1) ? 32'(amt) : 32'h0);
    chk("done_no_shift", NO_SHIFT, 32'h1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got result %h, expected none queued", DOUT);
    end else begin
      want = exp_q.pop_front();
      chk("dout_result", DOUT, want);
    end
    held = DOUT;
    repeat (hold) begin
      @(posedge CLK);
      #1;
      chk("dout_stable",       DOUT,        held);
      chk("res_valid_held",    RES_VALID,   32'h1);
      chk("start_ready_stall", START_READY, 32'h0);
    end
    RES_READY = 1'b1;
    START_VALID = 1'b1;
    @(posedge CLK);
    #1;
    RES_READY = 1'b0;
    START_VALID = 1'b0;
    chk("idle_after_take_busy",   BUSY,      32'h0);
    chk("idle_after_take_valid",  RES_VALID, 32'h0);
    chk("idle_after_take_ready",  START_READY, 32'h1);
  endtask

  initial begin
    vecs[0] = '{32'h0000_00F1, 5'd4,  1'b0, 1'b0, 32'h0000_0F10, 0};
    vecs[1] = '{32'h8000_0010, 5'd3,  1'b1, 1'b1, 32'h1000_0002, 0};
    vecs[2] = '{32'h1234_5678, 5'd0,  1'b0, 1'b0, 32'h1234_5678, 0};
    vecs[3] = '{32'hDEAD_BEEF, 5'd8,  1'b1, 1'b0, 32'h00DE_ADBE, 0};
    vecs[4] = '{32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000, 5};
    vecs[5] = '{32'hFFFF_FFFF, 5'd1,  1'b0, 1'b0, 32'hFFFF_FFFE, 0};
    vecs[6] = '{32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'h0000_0001, 1};
    vecs[7] = '{32'h0F0F_0F0F, 5'd16, 1'b1, 1'b1, 32'h0000_0F0F, 0};
    vecs[8] = '{32'h0000_0001, 5'd1,  1'b1, 1'b1, 32'h0000_0000, 0};
`ifdef SHIFT_ARITH_EN
    vecs[1].exp = 32'hF000_0002;
    vecs[6].exp = 32'hFFFF_FFFF;
`endif

    RESET_N     = 1'b0;
    START_VALID = 1'b0;
    DIN         = 32'h0;
    AMT         = 5'd0;
    DIR         = 1'b0;
`ifdef SHIFT_ARITH_EN
    ARITH       = 1'b0;
`endif
    ABORT       = 1'b0;
    RES_READY   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_outputs("por");
    @(negedge CLK);
    RESET_N = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].din, vecs[i].amt, vecs[i].dir, vecs[i].arith, vecs[i].exp, vecs[i].hold);
    end

    // ABORT while idle must not block acceptance
    @(negedge CLK);
    ABORT = 1'b1;
    START_VALID = 1'b1;
    DIN = 32'h0BAD_F00D;
    AMT = 5'd0;
    DIR = 1'b0;
    @(posedge CLK);
    #1;
    ABORT = 1'b0;
    START_VALID = 1'b0;
    chk("idle_abort_accepted", RES_VALID, 32'h1);
    chk("idle_abort_dout",     DOUT,      32'h0BAD_F00D);
    RES_READY = 1'b1;
    @(posedge CLK);
    #1;
    RES_READY = 1'b0;
    chk("idle_abort_released", BUSY, 32'h0);

    // ABORT two steps into a 10-step right shift
    @(negedge CLK);
    START_VALID = 1'b1;
    DIN = 32'hA5A5_0000;
    AMT = 5'd10;
    DIR = 1'b1;
`ifdef SHIFT_ARITH_EN
    ARITH = 1'b0;
`endif
    @(posedge CLK);
    #1;
    START_VALID = 1'b0;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    chk("abort_pre_dout", DOUT, 32'h2969_4000);
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    ABORT = 1'b0;
    chk("abort_busy",        BUSY,        32'h0);
    chk("abort_res_valid",   RES_VALID,   32'h0);
    chk("abort_dout_kept",   DOUT,        32'h2969_4000);
    chk("abort_start_ready", START_READY, 32'h1);
    run_op(32'h0000_0003, 5'd2, 1'b0, 1'b0, 32'h0000_000C, 0);

    // Asynchronous reset in the middle of a shift
    @(negedge CLK);
    START_VALID = 1'b1;
    DIN = 32'h00FF_00FF;
    AMT = 5'd10;
    DIR = 1'b0;
    @(posedge CLK);
    #1;
    START_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge CLK);
    RESET_N = 1'b1;
    run_op(32'h0000_00F1, 5'd4, 1'b0, 1'b0, 32'h0000_0F10, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
